// File: rtl/aliens_cs_sequencer.sv
// Clocked chip-select sequencer: priority region decode latched at strobe start, per-region wait states.
// Optional overlap pulse when CS_OVERLAP_DETECT_EN is defined.
module aliens_cs_sequencer #(
    parameter int ADDR_W = 16,
    parameter int NREG   = 4,
    parameter int MODE_W = 3,
    parameter int WAIT_W = 3,
    parameter logic [NREG*ADDR_W-1:0] REG_BASE = {16'h4000, 16'h7C00, 16'h5F80, 16'h0000},
    parameter logic [NREG*ADDR_W-1:0] REG_MASK = {16'hC000, 16'hFC00, 16'hFFE0, 16'hFC00},
    parameter logic [NREG*MODE_W-1:0] REG_MVAL = {3'b000, 3'b010, 3'b000, 3'b001},
    parameter logic [NREG*MODE_W-1:0] REG_MMSK = {3'b000, 3'b110, 3'b000, 3'b001},
    parameter logic [NREG*WAIT_W-1:0] REG_WAIT = {3'd1, 3'd0, 3'd2, 3'd0}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              as_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [MODE_W-1:0] mode,
    output logic [NREG-1:0]   cs_n,
    output logic              rdy,
    output logic              dec_err,
    output logic              overlap
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_NOMAP} state_t;

    state_t            r_state, w_state_nx;
    logic [NREG-1:0]   r_cs_n, w_cs_nx;
    logic              r_rdy, w_rdy_nx;
    logic              r_err, w_err_nx;
    logic [WAIT_W-1:0] r_cnt, w_cnt_nx;
    logic              r_as_q, r_armed;

    logic [NREG-1:0]   w_match, w_win_oh;
    logic [WAIT_W-1:0] w_win_wait;
    logic              w_hit, w_start;

    always_comb begin
        w_match    = '0;
        w_win_wait = '0;
        for (int i = 0; i < NREG; i++) begin
            w_match[i] = (((addr ^ REG_BASE[i*ADDR_W +: ADDR_W]) & REG_MASK[i*ADDR_W +: ADDR_W]) == '0) &&
                         (((mode ^ REG_MVAL[i*MODE_W +: MODE_W]) & REG_MMSK[i*MODE_W +: MODE_W]) == '0);
        end
        // Lowest set bit = highest-priority region.
        w_win_oh = w_match & (-w_match);
        for (int i = 0; i < NREG; i++)
            if (w_win_oh[i]) w_win_wait = REG_WAIT[i*WAIT_W +: WAIT_W];
    end

    assign w_hit = |w_match;
    // r_armed blocks a strobe that was already low when reset released.
    assign w_start = ~as_n & r_as_q & r_armed;

    always_comb begin
        w_state_nx = r_state;
        w_cs_nx    = r_cs_n;
        w_rdy_nx   = r_rdy;
        w_err_nx   = 1'b0;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_hit) begin
                        w_cs_nx = ~w_win_oh;
                        if (w_win_wait != '0) begin
                            w_state_nx = S_WAIT;
                            w_cnt_nx   = w_win_wait - 1'b1;
                            w_rdy_nx   = 1'b0;
                        end else begin
                            w_state_nx = S_ACTIVE;
                            w_rdy_nx   = 1'b1;
                        end
                    end else begin
                        w_state_nx = S_NOMAP;
                        w_err_nx   = 1'b1;
                        w_rdy_nx   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (as_n) begin
                    w_state_nx = S_IDLE;
                    w_cs_nx    = '1;
                    w_rdy_nx   = 1'b0;
                    w_cnt_nx   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nx = S_ACTIVE;
                    w_rdy_nx   = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_ACTIVE, S_NOMAP: begin
                if (as_n) begin
                    w_state_nx = S_IDLE;
                    w_cs_nx    = '1;
                    w_rdy_nx   = 1'b0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cs_nx    = '1;
                w_rdy_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cs_n  <= '1;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_as_q  <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cs_n  <= w_cs_nx;
            r_rdy   <= w_rdy_nx;
            r_err   <= w_err_nx;
            r_cnt   <= w_cnt_nx;
            r_as_q  <= as_n;
            r_armed <= r_armed | as_n;
        end
    end

    assign cs_n    = r_cs_n;
    assign rdy     = r_rdy;
    assign dec_err = r_err;

`ifdef CS_OVERLAP_DETECT_EN
    logic r_ovl;
    logic w_multi;
    assign w_multi = (w_match & (w_match - NREG'(1))) != '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ovl <= 1'b0;
        else       r_ovl <= (r_state == S_IDLE) && w_start && w_multi;
    end
    assign overlap = r_ovl;
`else
    assign overlap = 1'b0;
`endif

endmodule

// File: tb/tb_aliens_cs_sequencer.sv
// Self-checking bench for aliens_cs_sequencer: directed table, corner sequences, randomized
// transactions checked against a transaction-level reference model.
module tb_aliens_cs_sequencer;

`ifdef CS_OVERLAP_DETECT_EN
    localparam bit OVL_EN = 1'b1;
`else
    localparam bit OVL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        as_n;
    logic [15:0] addr;
    logic [2:0]  mode;
    logic [3:0]  cs_n;
    logic        rdy, dec_err, overlap;

    int checks   = 0;
    int failures = 0;

    aliens_cs_sequencer dut (
        .clk(clk), .reset(reset), .as_n(as_n), .addr(addr), .mode(mode),
        .cs_n(cs_n), .rdy(rdy), .dec_err(dec_err), .overlap(overlap)
    );

    always #5 clk = ~clk;

    // Region map from the board description: 0 CRAM, 1 IO, 2 OBJ, 3 VRAM.
    logic [15:0] m_base [4] = '{16'h0000, 16'h5F80, 16'h7C00, 16'h4000};
    logic [15:0] m_mask [4] = '{16'hFC00, 16'hFFE0, 16'hFC00, 16'hC000};
    logic [2:0]  m_mval [4] = '{3'b001, 3'b000, 3'b010, 3'b000};
    logic [2:0]  m_mmsk [4] = '{3'b001, 3'b000, 3'b110, 3'b000};
    int          m_wait [4] = '{0, 2, 0, 1};

    typedef struct {
        logic [15:0] a;
        logic [2:0]  m;
        int          hold;
        logic [3:0]  cs;
        int          w;
        bit          err;
        bit          ovl;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got{cs,rdy,err,ovl}=%b expected=%b at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {cs_n, rdy, dec_err, overlap};
    endfunction

    function automatic void ref_decode(input logic [15:0] a, input logic [2:0] m,
                                       output logic [3:0] cs, output int w,
                                       output bit err, output bit ovl);
        int nmatch = 0;
        int win = -1;
        for (int i = 0; i < 4; i++) begin
            if ((((a ^ m_base[i]) & m_mask[i]) == 16'h0) && (((m ^ m_mval[i]) & m_mmsk[i]) == 3'b0)) begin
                nmatch++;
                if (win < 0) win = i;
            end
        end
        err = (win < 0);
        ovl = (nmatch >= 2);
        w   = err ? 0 : m_wait[win];
        cs  = 4'hF;
        if (!err) cs[win] = 1'b0;
    endfunction

    task automatic step(input logic a_n, input logic [15:0] a, input logic [2:0] m);
        as_n = a_n;
        addr = a;
        mode = m;
        @(posedge clk);
        #1;
    endtask

    // One strobe: gap idle cycles, then hold low-sampled edges. Edge n (1-based) after the
    // start: select visible from n=1, rdy once n exceeds the wait count, pulses only at n=1.
    task automatic run_txn(input string nm, input logic [15:0] a, input logic [2:0] m,
                           input int gap, input int hold, input logic [3:0] ecs,
                           input int ew, input bit eerr, input bit eovl);
        logic [6:0] exp;
        for (int g = 0; g < gap; g++) begin
            step(1'b1, 16'($urandom), 3'($urandom));
            chk({nm, "/idle"}, outs(), 7'b1111_000);
        end
        for (int n = 1; n <= hold; n++) begin
            if (n == 1) step(1'b0, a, m);
            else        step(1'b0, 16'($urandom), 3'($urandom));
            exp = {eerr ? 4'hF : ecs, eerr ? 1'b1 : (n > ew), eerr && (n == 1), OVL_EN && eovl && (n == 1)};
            chk({nm, "/busy"}, outs(), exp);
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [2:0]  rm;
        logic [3:0]  rcs;
        int          rw;
        bit          rerr, rovl;
        logic [15:0] pool [6] = '{16'h0000, 16'h5F80, 16'h7C00, 16'h4000, 16'h2000, 16'hC000};

        tbl[0]  = '{16'h0123, 3'b001, 3, 4'b1110, 0, 1'b0, 1'b0};
        tbl[1]  = '{16'h5F85, 3'b000, 4, 4'b1101, 2, 1'b0, 1'b1};
        tbl[2]  = '{16'h7C10, 3'b010, 3, 4'b1011, 0, 1'b0, 1'b1};
        tbl[3]  = '{16'h7C10, 3'b110, 3, 4'b0111, 1, 1'b0, 1'b0};
        tbl[4]  = '{16'h2000, 3'b000, 3, 4'b1111, 0, 1'b1, 1'b0};
        tbl[5]  = '{16'h4800, 3'b000, 1, 4'b0111, 1, 1'b0, 1'b0};
        tbl[6]  = '{16'h5F9F, 3'b000, 2, 4'b1101, 2, 1'b0, 1'b1};
        tbl[7]  = '{16'h03FF, 3'b001, 2, 4'b1110, 0, 1'b0, 1'b0};
        tbl[8]  = '{16'h0400, 3'b001, 2, 4'b1111, 0, 1'b1, 1'b0};
        tbl[9]  = '{16'h7FFF, 3'b111, 3, 4'b0111, 1, 1'b0, 1'b0};
        tbl[10] = '{16'hFFFF, 3'b000, 2, 4'b1111, 0, 1'b1, 1'b0};

        reset = 1'b1;
        as_n  = 1'b1;
        addr  = '0;
        mode  = '0;
        #1;
        chk("reset_async", outs(), 7'b1111_000);
        @(posedge clk);
        #1;
        chk("reset_held", outs(), 7'b1111_000);
        reset = 1'b0;

        foreach (tbl[i])
            run_txn($sformatf("tbl%0d", i), tbl[i].a, tbl[i].m, 2, tbl[i].hold,
                    tbl[i].cs, tbl[i].w, tbl[i].err, tbl[i].ovl);

        // Decision stays latched while the strobe is held low.
        step(1'b1, 16'h0, 3'b0);
        chk("latch/idle", outs(), 7'b1111_000);
        step(1'b0, 16'h0010, 3'b001);
        chk("latch/sel", outs(), 7'b1110_100);
        step(1'b0, 16'h5F80, 3'b000);
        chk("latch/hold1", outs(), 7'b1110_100);
        step(1'b0, 16'h5F80, 3'b000);
        chk("latch/hold2", outs(), 7'b1110_100);
        step(1'b1, 16'h5F80, 3'b000);
        chk("latch/release", outs(), 7'b1111_000);

        // Reset mid-ACTIVE clears outputs without a clock edge, then a strobe low across release is ignored.
        step(1'b0, 16'h0123, 3'b001);
        chk("rst/active", outs(), 7'b1110_100);
        #3 reset = 1'b1;
        #1;
        chk("rst/immediate", outs(), 7'b1111_000);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 16'h0123, 3'b001);
            chk("rst/no_start", outs(), 7'b1111_000);
        end
        step(1'b1, 16'h0123, 3'b001);
        chk("rst/high", outs(), 7'b1111_000);
        step(1'b0, 16'h0123, 3'b001);
        chk("rst/restart", outs(), 7'b1110_100);

        for (int t = 0; t < 250; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                             : (pool[$urandom_range(0, 5)] | 16'($urandom_range(0, 31)));
            rm = 3'($urandom);
            ref_decode(ra, rm, rcs, rw, rerr, rovl);
            run_txn($sformatf("rnd%0d", t), ra, rm, $urandom_range(1, 3), $urandom_range(1, 5),
                    rcs, rw, rerr, rovl);
        end
        run_txn("tail", 16'h0, 3'b0, 2, 0, 4'hF, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aliens_cs_sequencer.md
Name: aliens_cs_sequencer

Overview:
- Parametrised, clocked chip-select generator for Konami-style 8-bit CPU boards; next generation of the single-PAL address decoders.
- Decodes an address/mode word against NREG programmable regions with fixed index priority.
- Latches the decode at address-strobe assertion and asserts exactly one active-low chip select.
- Inserts per-region wait states on a ready line; sits between the CPU bus and the CRAM/IO/OBJ/VRAM selects.

Parameters:
ADDR_W, 16, address width.
NREG, 4, number of regions; index 0 has highest priority.
MODE_W, 3, mode qualifier width; bit0 WOCO, bit1 INIT, bit2 RMRD.
WAIT_W, 3, wait-state counter width.
REG_BASE, {16'h4000,16'h7C00,16'h5F80,16'h0000}, NREG*ADDR_W flattened bases; region i in slice i.
REG_MASK, {16'hC000,16'hFC00,16'hFFE0,16'hFC00}, address bits compared (1 = compare).
REG_MVAL, {3'b000,3'b010,3'b000,3'b001}, required mode values.
REG_MMSK, {3'b000,3'b110,3'b000,3'b001}, mode bits compared.
REG_WAIT, {3'd1,3'd0,3'd2,3'd0}, wait cycles per region.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
as_n  input  1  CPU address strobe, active low, synchronous to clk.
addr  input  ADDR_W  CPU address.
mode  input  MODE_W  qualifiers {RMRD, INIT, WOCO}.
cs_n  output  NREG  chip selects, active low, at most one low.
rdy  output  1  bus ready, high = cycle may complete.
dec_err  output  1  one-cycle pulse on an unmapped access.
overlap  output  1  see Optional Feature.

Behaviour:
- Match for region i: ((addr^BASE_i)&MASK_i)==0 and ((mode^MVAL_i)&MMSK_i)==0.
- Winner: lowest matching index.
- Reset (asynchronous, any state): state=IDLE, cs_n=all 1, rdy=0, dec_err=0, overlap=0, wait counter=0, as_q=1.
- as_q is as_n registered. A strobe start is as_n==0 with as_q==1.
- IDLE: on strobe start, latch addr/mode and the winner index.
  - Winner with REG_WAIT>0: next state WAIT, counter=REG_WAIT-1, cs_n[win]=0, rdy=0.
  - Winner with REG_WAIT==0: next state ACTIVE, cs_n[win]=0, rdy=1.
  - No winner: next state NOMAP, dec_err=1 for one cycle, rdy=1, all cs_n stay 1.
- Select latency is 1 clk from the first edge sampling as_n low. ACTIVE is therefore reached REG_WAIT+1 edges after start.
- WAIT: counter decrements each clk. At counter==0 go to ACTIVE with rdy=1. cs_n held.
- ACTIVE / NOMAP: hold outputs while as_n low. On as_n sampled high: cs_n=all 1, rdy=0, go to IDLE in the same edge.
- as_n high during WAIT: abort. cs_n=all 1, rdy=0, go to IDLE; no rdy pulse is ever produced for an aborted cycle.
- addr/mode changes while as_n stays low are ignored; the decision stays latched.
- as_n low and already low at reset release: not a start. Wait for a high-then-low transition.
- Back-to-back strobes: needs as_n high for at least one clk; IDLE then accepts the new start on the next low sample.
- REG_WAIT values at the WAIT_W maximum must work without counter overflow.

Optional Feature:
- Macro CS_OVERLAP_DETECT_EN.
- Defined: overlap pulses high for one clk, coincident with cs_n assertion, when two or more regions match the latched access. The priority winner is still selected.
- Undefined: overlap tied to 0; no extra logic.

Test Plan:
- CRAM: addr=16'h0123, mode=3'b001, as_n falls -> one clk later cs_n=4'b1110, rdy=1; as_n rises -> cs_n=4'b1111, rdy=0 next edge.
- IO wait: addr=16'h5F85, mode=0 -> cs_n=4'b1101, rdy=0 for 2 clks, then rdy=1. With the macro defined, overlap=1 on the assertion cycle (the access also matches VRAM).
- OBJ priority: addr=16'h7C10, mode=3'b010 -> cs_n=4'b1011, rdy=1 immediately. Same addr with mode=3'b110 (RMRD=1) -> VRAM selected (cs_n=4'b0111) after 1 wait cycle.
- Unmapped: addr=16'h2000, mode=0 -> dec_err pulses 1 clk, rdy=1, cs_n=4'b1111.
- Abort and reset: VRAM access at 16'h4800 with as_n raised during WAIT -> no rdy pulse, IDLE. Assert reset mid-ACTIVE -> cs_n=4'b1111, rdy=0 immediately without a clk edge.
- Latch stability: start at 16'h0010 with WOCO=1, change addr to 16'h5F80 while as_n stays low -> cs_n stays 4'b1110 until as_n rises.
